lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 71 +++++++
 rtl/lsu_ctrl_if.sv | 50 +++++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit controller:
//   state_e   - controller FSM states
//   err_e     - response error codes returned on rsp_err
//   F3_*      - RISC-V load/store funct3 encodings
//   size_mask - byte mask for an access size (funct3[1:0])
//   f3_legal  - funct3 legality for a given direction and data width
//   misaligned- natural-alignment check for an access size
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_FUNCT3   = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } err_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Byte mask for 1, 2, 4 or 8 byte accesses.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Unsigned loads have no store counterpart; 64-bit accesses need a 64-bit bus.
   function automatic logic f3_legal(input logic [2:0] f3, input logic wen, input logic is64);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_D:             ok = is64;
         F3_BU, F3_HU:     ok = !wen;
         F3_WU:            ok = !wen && is64;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
      logic m;
      case (size)
         2'b01:   m = lo[0];
         2'b10:   m = |lo[1:0];
         2'b11:   m = |lo;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the core request/response handshakes and the memory command/read
// channel of the load/store unit.
//   req_*  : core -> LSU request (valid/ready, wen, funct3, addr, wdata)
//   rsp_*  : LSU -> core response (valid/ready, rdata, err)
//   mem_*  : LSU -> memory command (valid/ready, wen, addr, wdata, wstrb)
//            memory -> LSU read data / write acknowledge (rvalid, rdata)
// Modports: slave  = the LSU controller side
//           master = the environment (core + memory) side
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [2:0]            req_funct3;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [1:0]            rsp_err;

   logic                  mem_valid;
   logic                  mem_ready;
   logic                  mem_wen;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
      input  rsp_ready, mem_ready, mem_rvalid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output req_valid, req_wen, req_funct3, req_addr, req_wdata,
      output rsp_ready, mem_ready, mem_rvalid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane alignment for the LSU.
//   i_funct3 : access funct3 (size in [1:0], unsigned flag in [2])
//   i_off    : byte offset of the access inside the bus word
//   i_wdata  : LSB-aligned store data
//   i_rdata  : raw memory read word
//   o_wdata  : store data shifted into its byte lanes
//   o_wstrb  : byte strobes for the access
//   o_rdata  : load data shifted down and sign/zero extended to DATA_W
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]                  i_funct3,
   input  logic [$clog2(DATA_W/8)-1:0] i_off,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [DATA_W-1:0]           i_rdata,
   output logic [DATA_W-1:0]           o_wdata,
   output logic [DATA_W/8-1:0]         o_wstrb,
   output logic [DATA_W-1:0]           o_rdata
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   logic [OFF_W+2:0]  w_shamt;
   logic [DATA_W-1:0] w_rsh;

   // Byte offset to bit offset.
   assign w_shamt = {i_off, 3'b000};
   assign o_wdata = i_wdata << w_shamt;
   // Mask is 8 bits wide; a 32-bit bus never sees the double-word mask.
   assign o_wstrb = STRB_W'(size_mask(i_funct3[1:0])) << i_off;
   assign w_rsh   = i_rdata >> w_shamt;

   always_comb begin
      o_rdata = w_rsh;
      case (i_funct3)
         F3_B:    o_rdata = DATA_W'($signed(w_rsh[7:0]));
         F3_H:    o_rdata = DATA_W'($signed(w_rsh[15:0]));
         F3_W:    o_rdata = DATA_W'($signed(w_rsh[31:0]));
         F3_BU:   o_rdata = DATA_W'(w_rsh[7:0]);
         F3_HU:   o_rdata = DATA_W'(w_rsh[15:0]);
         F3_WU:   o_rdata = DATA_W'(w_rsh[31:0]);
         default: o_rdata = w_rsh;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller: accepts one core request at a time, checks
// funct3 and alignment, issues a single memory command, waits (bounded by
// LAT_MAX cycles) for read data / write acknowledge and returns an extended
// load result with an error code.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : lsu_ctrl_if.slave (req_*, rsp_*, mem_* channels)
// -----------------------------------------------------------------------------
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int LAT_MAX = 15
) (
   input  logic      clk,
   input  logic      rst,
   lsu_ctrl_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   state_e               r_state;
   state_e               w_state_nxt;

   logic                 r_wen;
   logic [2:0]           r_funct3;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_wdata;
   logic [CNT_W-1:0]     r_cnt;
   logic [DATA_W-1:0]    r_rsp_rdata;
   err_e                 r_rsp_err;

   err_e                 w_req_err;
   logic                 w_timeout;
   logic [DATA_W-1:0]    w_wdata_sh;
   logic [STRB_W-1:0]    w_wstrb;
   logic [DATA_W-1:0]    w_rdata_ext;

   lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_funct3 (r_funct3),
      .i_off    (r_addr[OFF_W-1:0]),
      .i_wdata  (r_wdata),
      .i_rdata  (bus.mem_rdata),
      .o_wdata  (w_wdata_sh),
      .o_wstrb  (w_wstrb),
      .o_rdata  (w_rdata_ext)
   );

   // Illegal funct3 takes precedence; alignment is only meaningful for a legal size.
   always_comb begin
      w_req_err = ERR_OK;
      if (!f3_legal(bus.req_funct3, bus.req_wen, (DATA_W == 64)))
         w_req_err = ERR_FUNCT3;
      else if (misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]))
         w_req_err = ERR_MISALIGN;
   end

   // Last WAIT cycle of the LAT_MAX-cycle window.
   assign w_timeout = (r_cnt == CNT_W'(LAT_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.mem_valid = 1'b0;
      bus.rsp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               w_state_nxt = (w_req_err == ERR_OK) ? S_CMD : S_RESP;
         end
         S_CMD: begin
            bus.mem_valid = 1'b1;
            if (bus.mem_ready) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rvalid || w_timeout) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen       <= 1'b0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= ERR_OK;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_wen       <= bus.req_wen;
                  r_funct3    <= bus.req_funct3;
                  r_addr      <= bus.req_addr;
                  r_wdata     <= bus.req_wdata;
                  r_cnt       <= '0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= w_req_err;
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  r_rsp_rdata <= r_wen ? '0 : w_rdata_ext;
                  r_rsp_err   <= ERR_OK;
               end else if (w_timeout) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= ERR_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_wen   = r_wen;
   assign bus.mem_addr  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign bus.mem_wdata = w_wdata_sh;
   // Strobes only drive while a command is on the bus.
   assign bus.mem_wstrb = (r_state == S_CMD) ? w_wstrb : '0;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed self-checking bench for lsu_ctrl (DATA_W=32, ADDR_W=32, LAT_MAX=15).
// Expected responses are queued when a request is driven and compared when
// the controller raises rsp_valid.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;
   import lsu_pkg::*;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int LAT_MAX = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;
   exp_t sb_q[$];

   lsu_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   lsu_ctrl #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .LAT_MAX (LAT_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_wen    = wen;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
   endtask

   task automatic push_exp(input logic [31:0] r, input logic [1:0] e);
      exp_t x;
      x.rdata = r;
      x.err   = e;
      sb_q.push_back(x);
   endtask

   // Waits (bounded) for rsp_valid, compares against the scoreboard head,
   // optionally holds rsp_ready low to check stability, then completes it.
   task automatic wait_rsp(input string tag, input int lat_in, input int hold, output int lat_out);
      exp_t x;
      int   lat;
      lat = lat_in;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      lat_out = lat;
      chk({tag, "_rsp_seen"}, bus.rsp_valid, 1);
      chk({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
      if (bus.rsp_valid === 1'b1 && sb_q.size() != 0) begin
         x = sb_q.pop_front();
         chk({tag, "_rdata"}, bus.rsp_rdata, x.rdata);
         chk({tag, "_err"}, bus.rsp_err, x.err);
         for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
            chk({tag, "_hold_rdata"}, bus.rsp_rdata, x.rdata);
            chk({tag, "_hold_err"}, bus.rsp_err, x.err);
         end
      end else if (sb_q.size() != 0) begin
         void'(sb_q.pop_front());
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   // One transaction against a zero-wait memory.
   task automatic xact(input string tag, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_rdata, input logic [1:0] e_err, input int e_lat, input int hold);
      int lat;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      drive_req(wen, f3, addr, wdata);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      push_exp(e_rdata, e_err);
      tick();
      bus.req_valid = 1'b0;
      if (e_err == 2'b00) begin
         chk({tag, "_mem_valid"}, bus.mem_valid, 1);
         chk({tag, "_mem_addr"}, bus.mem_addr, e_addr);
         chk({tag, "_mem_wen"}, bus.mem_wen, wen);
         if (wen) begin
            chk({tag, "_mem_wstrb"}, bus.mem_wstrb, e_strb);
            chk({tag, "_mem_wdata"}, bus.mem_wdata, e_wdata);
         end
      end else begin
         chk({tag, "_no_mem_valid"}, bus.mem_valid, 0);
      end
      wait_rsp(tag, 1, hold, lat);
      chk({tag, "_latency"}, lat, e_lat);
      bus.mem_rvalid = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_mem_valid", bus.mem_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_mem_wstrb", bus.mem_wstrb, 0);
      rst = 1'b0;
      tick();

      // Loads and stores with zero-wait memory
      xact("lb_103", 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_FF00,
           32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 2'b00, 3, 2);
      xact("sh_202", 1'b1, F3_H, 32'h202, 32'h0000_ABCD, 32'h1234_5678,
           32'h200, 4'b1100, 32'hABCD_0000, 32'h0, 2'b00, 3, 0);
      xact("sb_103", 1'b1, F3_B, 32'h103, 32'h0000_005A, 32'h0,
           32'h100, 4'b1000, 32'h5A00_0000, 32'h0, 2'b00, 3, 0);
      xact("sw_100", 1'b1, F3_W, 32'h100, 32'hCAFE_BABE, 32'h0,
           32'h100, 4'b1111, 32'hCAFE_BABE, 32'h0, 2'b00, 3, 0);
      xact("lh_100", 1'b0, F3_H, 32'h100, 32'h0, 32'h0000_8001,
           32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 2'b00, 3, 0);
      xact("lbu_101", 1'b0, F3_BU, 32'h101, 32'h0, 32'h0000_F000,
           32'h100, 4'h0, 32'h0, 32'h0000_00F0, 2'b00, 3, 0);
      xact("lw_104", 1'b0, F3_W, 32'h104, 32'h0, 32'h8765_4321,
           32'h104, 4'h0, 32'h0, 32'h8765_4321, 2'b00, 3, 0);

      // Error path: misaligned and illegal funct3
      xact("lw_101_mis", 1'b0, F3_W, 32'h101, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 1);
      xact("sh_201_mis", 1'b1, F3_H, 32'h201, 32'h1111, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 0);
      xact("ld_on32", 1'b0, F3_D, 32'h100, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1, 0);
      xact("st_f3_100", 1'b1, F3_BU, 32'h100, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1, 0);
      xact("ld_f3_111", 1'b0, 3'b111, 32'h100, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1, 0);

      // LHU with mem_ready held low for 4 cycles; stray mem_rvalid during CMD
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h9234_0000;
      drive_req(1'b0, F3_HU, 32'h102, 32'h0);
      push_exp(32'h0000_9234, 2'b00);
      tick();
      bus.req_valid = 1'b0;
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         chk("lhu_stall_mem_valid", bus.mem_valid, 1);
         chk("lhu_stall_mem_addr", bus.mem_addr, 32'h100);
         chk("lhu_stall_no_rsp", bus.rsp_valid, 0);
         tick();
         lat++;
      end
      bus.mem_ready = 1'b1;
      chk("lhu_cmd_still_valid", bus.mem_valid, 1);
      wait_rsp("lhu_stall", lat, 0, lat);
      chk("lhu_stall_latency", lat, 7);
      bus.mem_rvalid = 1'b0;

      // Timeout: mem_rvalid never arrives
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      drive_req(1'b0, F3_W, 32'h104, 32'h0);
      push_exp(32'h0, 2'b11);
      tick();
      bus.req_valid = 1'b0;
      wait_rsp("timeout", 1, 0, lat);
      chk("timeout_latency", lat, 2 + LAT_MAX);

      // Reset while in WAIT, then a late mem_rvalid
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      drive_req(1'b0, F3_W, 32'h108, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      tick();
      chk("rstwait_in_wait_no_mem_valid", bus.mem_valid, 0);
      chk("rstwait_in_wait_not_ready", bus.req_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstwait_req_ready", bus.req_ready, 1);
      chk("rstwait_rsp_valid", bus.rsp_valid, 0);
      chk("rstwait_rsp_err", bus.rsp_err, 0);
      chk("rstwait_rsp_rdata", bus.rsp_rdata, 0);
      chk("rstwait_mem_wstrb", bus.mem_wstrb, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstwait_stray_no_rsp", bus.rsp_valid, 0);
         chk("rstwait_stray_ready", bus.req_ready, 1);
      end
      bus.mem_rvalid = 1'b0;

      // Reset mid-CMD aborts the command
      bus.mem_ready = 1'b0;
      drive_req(1'b0, F3_W, 32'h10C, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("rstcmd_mem_valid_before", bus.mem_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      chk("rstcmd_mem_valid_after", bus.mem_valid, 0);
      chk("rstcmd_req_ready", bus.req_ready, 1);
      tick();
      chk("rstcmd_no_resume", bus.mem_valid, 0);

      // Normal operation after recovery
      xact("lw_10c_recover", 1'b0, F3_W, 32'h10C, 32'h0, 32'h1357_9BDF,
           32'h10C, 4'h0, 32'h0, 32'h1357_9BDF, 2'b00, 3, 0);

      chk("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
